// File: rtl/jtoutrun_ram_arb.sv
// Round-robin arbiter sharing one work-RAM port between the OutRun main and sub 68000s.
// Each side holds cs until it sees its ok; fields are latched at grant time.
module jtoutrun_ram_arb #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          main_cs,
  input  logic [AW-1:0] main_addr,
  input  logic          main_we,
  input  logic [1:0]    main_dsn,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_ok,
  input  logic          sub_cs,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_we,
  input  logic [1:0]    sub_dsn,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_ok,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_dsn,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ok
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  localparam logic MAIN = 1'b0;
  localparam logic SUB  = 1'b1;

  state_t        state_reg, state_next;
  logic          gnt_reg, gnt_next;
  logic          last_reg, last_next;
  logic          skip_reg, skip_next;
  logic          mem_cs_next, mem_we_next;
  logic [AW-1:0] mem_addr_next;
  logic [1:0]    mem_dsn_next;
  logic [DW-1:0] mem_din_next;
  logic [DW-1:0] main_dout_next, sub_dout_next;
  logic          main_ok_next, sub_ok_next;
  logic          pick;
  logic          cs_gnt;

  // Sub wins only when main is idle or main was the last one served.
  assign pick   = sub_cs && (!main_cs || last_reg == MAIN);
  assign cs_gnt = (gnt_reg == SUB) ? sub_cs : main_cs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= MAIN;
      last_reg  <= SUB;
      skip_reg  <= 1'b0;
      mem_cs    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_dsn   <= 2'b11;
      mem_din   <= '0;
      main_dout <= '0;
      sub_dout  <= '0;
      main_ok   <= 1'b0;
      sub_ok    <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
      skip_reg  <= skip_next;
      mem_cs    <= mem_cs_next;
      mem_addr  <= mem_addr_next;
      mem_we    <= mem_we_next;
      mem_dsn   <= mem_dsn_next;
      mem_din   <= mem_din_next;
      main_dout <= main_dout_next;
      sub_dout  <= sub_dout_next;
      main_ok   <= main_ok_next;
      sub_ok    <= sub_ok_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    last_next      = last_reg;
    skip_next      = skip_reg;
    mem_cs_next    = mem_cs;
    mem_addr_next  = mem_addr;
    mem_we_next    = mem_we;
    mem_dsn_next   = mem_dsn;
    mem_din_next   = mem_din;
    main_dout_next = main_dout;
    sub_dout_next  = sub_dout;
    main_ok_next   = main_ok;
    sub_ok_next    = sub_ok;

    case (state_reg)
      IDLE: begin
        if (main_cs || sub_cs) begin
          gnt_next      = pick;
          mem_addr_next = pick ? sub_addr : main_addr;
          mem_we_next   = pick ? sub_we   : main_we;
          mem_dsn_next  = pick ? sub_dsn  : main_dsn;
          mem_din_next  = pick ? sub_din  : main_din;
          mem_cs_next   = 1'b1;
          skip_next     = 1'b1;
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        // The slot may still show the previous access's ok on the first cycle.
        skip_next = 1'b0;
        if (!skip_reg && mem_ok) begin
          mem_cs_next = 1'b0;
          last_next   = gnt_reg;
          if (cs_gnt) begin
            if (gnt_reg == SUB) begin
              sub_ok_next = 1'b1;
              if (!mem_we) sub_dout_next = mem_dout;
            end else begin
              main_ok_next = 1'b1;
              if (!mem_we) main_dout_next = mem_dout;
            end
            state_next = HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (!cs_gnt) begin
          if (gnt_reg == SUB) sub_ok_next = 1'b0;
          else                main_ok_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtoutrun_ram_arb.sv
// Bench for jtoutrun_ram_arb: a memory slot with programmable latency plus a
// transaction-level round-robin/memory reference model.
module tb_jtoutrun_ram_arb;
  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          main_cs = 1'b0, sub_cs = 1'b0;
  logic [AW-1:0] main_addr = '0, sub_addr = '0;
  logic          main_we = 1'b0, sub_we = 1'b0;
  logic [1:0]    main_dsn = 2'b11, sub_dsn = 2'b11;
  logic [DW-1:0] main_din = '0, sub_din = '0;
  logic [DW-1:0] main_dout, sub_dout;
  logic          main_ok, sub_ok;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_dsn;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_ok = 1'b0;

  jtoutrun_ram_arb #(.AW(AW), .DW(DW)) dut (
    .rst(rst), .clk(clk),
    .main_cs(main_cs), .main_addr(main_addr), .main_we(main_we), .main_dsn(main_dsn),
    .main_din(main_din), .main_dout(main_dout), .main_ok(main_ok),
    .sub_cs(sub_cs), .sub_addr(sub_addr), .sub_we(sub_we), .sub_dsn(sub_dsn),
    .sub_din(sub_din), .sub_dout(sub_dout), .sub_ok(sub_ok),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dsn(mem_dsn),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ok(mem_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] memarr [0:16383];
  logic [15:0] refmem [0:16383];
  int lat = 3;
  bit force_ok = 1'b0;
  int hold_n = 2;

  logic [AW-1:0] e_addr [2];
  logic          e_we   [2];
  logic [1:0]    e_dsn  [2];
  logic [DW-1:0] e_din  [2];
  logic [DW-1:0] exp_dout [2];
  bit            ref_last = 1'b1;

  // Memory slot: mem_ok rises 'lat' cycles after mem_cs; writes commit with ok.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_cs) cnt = 0;
      else cnt++;
      mem_dout = memarr[mem_addr];
      if (mem_cs && cnt == lat && mem_we) begin
        if (!mem_dsn[1]) memarr[mem_addr][15:8] = mem_din[15:8];
        if (!mem_dsn[0]) memarr[mem_addr][7:0]  = mem_din[7:0];
      end
      mem_ok = force_ok || (mem_cs && cnt == lat);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic okv(input bit w);
    return w ? sub_ok : main_ok;
  endfunction

  function automatic logic [DW-1:0] doutv(input bit w);
    return w ? sub_dout : main_dout;
  endfunction

  task automatic set_req(input bit w, input logic [AW-1:0] a, input logic we,
                         input logic [1:0] dsn, input logic [DW-1:0] din);
    e_addr[w] = a; e_we[w] = we; e_dsn[w] = dsn; e_din[w] = din;
    if (w) begin
      sub_addr = a; sub_we = we; sub_dsn = dsn; sub_din = din; sub_cs = 1'b1;
    end else begin
      main_addr = a; main_we = we; main_dsn = dsn; main_din = din; main_cs = 1'b1;
    end
  endtask

  task automatic serve(input bit w);
    int k;
    bit found;
    int exp_lat;
    exp_lat = force_ok ? 2 : lat;
    found = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_cs) begin found = 1'b1; break; end
    end
    chk("grant_seen", 32'(found), 32'd1);
    chk("grant_latency", 32'(k), 32'd1);
    chk("mem_addr", 32'(mem_addr), 32'(e_addr[w]));
    chk("mem_we", 32'(mem_we), 32'(e_we[w]));
    chk("mem_dsn", 32'(mem_dsn), 32'(e_dsn[w]));
    chk("mem_din", 32'(mem_din), 32'(e_din[w]));
    // Changing the granted side's fields now must not disturb the access.
    if (w) begin sub_addr = ~sub_addr; sub_din = ~sub_din; end
    else   begin main_addr = ~main_addr; main_din = ~main_din; end
    found = 1'b0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (okv(w)) begin found = 1'b1; break; end
    end
    chk("ok_seen", 32'(found), 32'd1);
    chk("ok_latency", 32'(k), 32'(exp_lat));
    chk("other_ok", 32'(okv(!w)), 32'd0);
    if (!e_we[w]) exp_dout[w] = refmem[e_addr[w]];
    else begin
      if (!e_dsn[w][1]) refmem[e_addr[w]][15:8] = e_din[w][15:8];
      if (!e_dsn[w][0]) refmem[e_addr[w]][7:0]  = e_din[w][7:0];
    end
    chk(w ? "sub_dout" : "main_dout", 32'(doutv(w)), 32'(exp_dout[w]));
    chk("other_dout", 32'(doutv(!w)), 32'(exp_dout[!w]));
    ref_last = w;
    repeat (hold_n) begin
      @(posedge clk); #1;
      chk("ok_hold", 32'(okv(w)), 32'd1);
    end
    @(negedge clk);
    if (w) sub_cs = 1'b0; else main_cs = 1'b0;
    @(posedge clk); #1;
    chk("ok_fall", 32'(okv(w)), 32'd0);
    chk("mem_cs_idle", 32'(mem_cs), 32'd0);
  endtask

  task automatic run(input bit m_en, input bit s_en);
    bit first;
    first = (m_en && s_en) ? !ref_last : !m_en;
    serve(first);
    if (m_en && s_en) serve(!first);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      memarr[i] = 16'($urandom);
      refmem[i] = memarr[i];
    end
    memarr[14'h0123] = 16'hBEEF;
    refmem[14'h0123] = 16'hBEEF;
    exp_dout[0] = '0;
    exp_dout[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_main_ok", 32'(main_ok), 32'd0);
    chk("rst_sub_ok", 32'(sub_ok), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_dsn", 32'(mem_dsn), 32'd3);
    chk("rst_main_dout", 32'(main_dout), 32'd0);

    // Tie after reset: main first, then sub
    @(negedge clk);
    set_req(0, 14'h0010, 1'b0, 2'b00, 16'h0);
    set_req(1, 14'h0456, 1'b0, 2'b00, 16'h0);
    run(1, 1);

    // Main read alone, memory answers 3 cycles after mem_cs
    lat = 3; hold_n = 3;
    @(negedge clk);
    set_req(0, 14'h0123, 1'b0, 2'b00, 16'h0);
    run(1, 0);

    // Sustained contention with byte-masked writes, then read back
    lat = 2; hold_n = 0;
    @(negedge clk);
    set_req(0, 14'h0020, 1'b1, 2'b00, 16'h1234);
    set_req(1, 14'h0020, 1'b1, 2'b10, 16'h55AA);
    run(1, 1);
    @(negedge clk);
    set_req(0, 14'h0020, 1'b0, 2'b00, 16'h0);
    set_req(1, 14'h0021, 1'b0, 2'b00, 16'h0);
    run(1, 1);

    // Stale ok: mem_ok high before the grant
    @(negedge clk);
    force_ok = 1'b1;
    set_req(0, 14'h0030, 1'b0, 2'b00, 16'h0);
    run(1, 0);
    @(negedge clk) force_ok = 1'b0;

    // Abort: sub drops cs right after grant, main waits
    lat = 4;
    @(negedge clk);
    set_req(1, 14'h0200, 1'b0, 2'b00, 16'h0);
    @(posedge clk); #1;
    chk("abort_grant", 32'(mem_cs), 32'd1);
    @(negedge clk);
    sub_cs = 1'b0;
    set_req(0, 14'h0300, 1'b0, 2'b00, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("abort_mem_cs_held", 32'(mem_cs), 32'd1);
      chk("abort_sub_ok", 32'(sub_ok), 32'd0);
    end
    @(posedge clk); #1;
    chk("abort_mem_cs_drop", 32'(mem_cs), 32'd0);
    chk("abort_sub_ok_end", 32'(sub_ok), 32'd0);
    chk("abort_sub_dout", 32'(sub_dout), 32'(exp_dout[1]));
    ref_last = 1'b1;
    serve(0);

    // Asynchronous reset in the middle of an access
    lat = 6;
    @(negedge clk);
    set_req(0, 14'h0040, 1'b0, 2'b00, 16'h0);
    @(posedge clk); #1;
    chk("pre_rst_mem_cs", 32'(mem_cs), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("async_rst_main_ok", 32'(main_ok), 32'd0);
    chk("async_rst_mem_dsn", 32'(mem_dsn), 32'd3);
    chk("async_rst_main_dout", 32'(main_dout), 32'd0);
    main_cs = 1'b0;
    exp_dout[0] = '0; exp_dout[1] = '0; ref_last = 1'b1;
    @(negedge clk) rst = 1'b0;
    lat = 3;
    @(negedge clk);
    set_req(0, 14'h0041, 1'b0, 2'b00, 16'h0);
    set_req(1, 14'h0042, 1'b0, 2'b00, 16'h0);
    run(1, 1);

    // Randomized traffic on a small address window
    for (int r = 0; r < 16; r++) begin
      bit m, s;
      lat = $urandom_range(2, 5);
      hold_n = $urandom_range(0, 2);
      m = 1'($urandom);
      s = 1'($urandom);
      if (!m && !s) m = 1'b1;
      @(negedge clk);
      if (m) set_req(0, 14'($urandom_range(0, 15)), 1'($urandom), 2'($urandom), 16'($urandom));
      if (s) set_req(1, 14'($urandom_range(0, 15)), 1'($urandom), 2'($urandom), 16'($urandom));
      run(m, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
